// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the execute stage.
//   DATA_W          datapath / operand width
//   INSTR_W         instruction width
//   IMM_MSB/IMM_LSB immediate field bounds inside the instruction
//   alu_op_t        ALU operation encoding
package ex_pkg;

   localparam int DATA_W  = 8;
   localparam int INSTR_W = 19;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SHL = 3'b101,
      ALU_SHR = 3'b110,
      ALU_ROR = 3'b111
   } alu_op_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: ID/EX inputs, stall/flush control and EX/MEM outputs
// of the execute stage, bundled into one interface.
//   master : the side driving ID/EX and the hazard controls
//   slave  : the execute stage itself
interface ex_mem_stage_if;
   import ex_pkg::*;

   logic                stall;
   logic                flush;

   logic [DATA_W-1:0]   ID_EX_A;
   logic [DATA_W-1:0]   ID_EX_B;
   logic [INSTR_W-1:0]  ID_EX_instruction;
   logic                ID_EX_mem_write;
   logic                ID_EX_reg_write;
   logic                ID_EX_alu_use_carry;
   logic                ID_EX_alu_in_mux;
   logic                ID_EX_select_c;
   logic                ID_EX_select_z;
   logic                ID_EX_write_c;
   logic                ID_EX_write_z;
   logic [2:0]          ID_EX_alu_op;
   logic [1:0]          ID_EX_reg_write_mux;

   logic [DATA_W-1:0]   EX_MEM_result;
   logic [DATA_W-1:0]   EX_MEM_B;
   logic [INSTR_W-1:0]  EX_MEM_instruction;
   logic                EX_MEM_mem_write;
   logic                EX_MEM_reg_write;
   logic [1:0]          EX_MEM_reg_write_mux;
   logic                carry_flag;
   logic                zero_flag;

   modport master (
      output stall, flush,
      output ID_EX_A, ID_EX_B, ID_EX_instruction, ID_EX_mem_write, ID_EX_reg_write,
      output ID_EX_alu_use_carry, ID_EX_alu_in_mux, ID_EX_select_c, ID_EX_select_z,
      output ID_EX_write_c, ID_EX_write_z, ID_EX_alu_op, ID_EX_reg_write_mux,
      input  EX_MEM_result, EX_MEM_B, EX_MEM_instruction, EX_MEM_mem_write,
      input  EX_MEM_reg_write, EX_MEM_reg_write_mux, carry_flag, zero_flag
   );

   modport slave (
      input  stall, flush,
      input  ID_EX_A, ID_EX_B, ID_EX_instruction, ID_EX_mem_write, ID_EX_reg_write,
      input  ID_EX_alu_use_carry, ID_EX_alu_in_mux, ID_EX_select_c, ID_EX_select_z,
      input  ID_EX_write_c, ID_EX_write_z, ID_EX_alu_op, ID_EX_reg_write_mux,
      output EX_MEM_result, EX_MEM_B, EX_MEM_instruction, EX_MEM_mem_write,
      output EX_MEM_reg_write, EX_MEM_reg_write_mux, carry_flag, zero_flag
   );

endinterface

// File: rtl/ex_mem_stage_alu_core.sv
// alu_core: combinational 8-bit ALU.
//   i_a, i_bop : operands (i_bop ignored by shifts)
//   i_cin      : carry-in / borrow-in / shift-in bit
//   i_op       : operation
//   o_r        : result
//   o_co       : arithmetic carry (ADD) or borrow (SUB), else 0
//   o_so       : bit shifted out (SHL/SHR/ROR), else 0
module alu_core
   import ex_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_bop,
   input  logic              i_cin,
   input  alu_op_t           i_op,
   output logic [DATA_W-1:0] o_r,
   output logic              o_co,
   output logic              o_so
);

   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_diff;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_bop} + {{DATA_W{1'b0}}, i_cin};
   // The 9th bit of the widened difference is set exactly when A < Bop + cin.
   assign w_diff = {1'b0, i_a} - {1'b0, i_bop} - {{DATA_W{1'b0}}, i_cin};

   always_comb begin
      o_r  = '0;
      o_co = 1'b0;
      o_so = 1'b0;
      case (i_op)
         ALU_ADD: begin
            o_r  = w_sum[DATA_W-1:0];
            o_co = w_sum[DATA_W];
         end
         ALU_SUB: begin
            o_r  = w_diff[DATA_W-1:0];
            o_co = w_diff[DATA_W];
         end
         ALU_AND: o_r = i_a & i_bop;
         ALU_OR:  o_r = i_a | i_bop;
         ALU_XOR: o_r = i_a ^ i_bop;
         ALU_SHL: begin
            o_r  = {i_a[DATA_W-2:0], i_cin};
            o_so = i_a[DATA_W-1];
         end
         ALU_SHR: begin
            o_r  = {i_cin, i_a[DATA_W-1:1]};
            o_so = i_a[0];
         end
         ALU_ROR: begin
            o_r  = {i_a[0], i_a[DATA_W-1:1]};
            o_so = i_a[0];
         end
         default: o_r = '0;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus EX/MEM pipeline register.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all registers and flags
//   bus   : ex_mem_stage_if.slave -- ID/EX inputs, stall/flush, EX/MEM
//           outputs and the current carry/zero flags
// Stall freezes everything (even over flush). Flush loads a zero bubble
// and leaves the flags untouched.
module ex_mem_stage
   import ex_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   ex_mem_stage_if.slave  bus
);

   logic [DATA_W-1:0]  r_result;
   logic [DATA_W-1:0]  r_b;
   logic [INSTR_W-1:0] r_instr;
   logic               r_mem_write;
   logic               r_reg_write;
   logic [1:0]         r_reg_write_mux;
   logic               r_c;
   logic               r_z;

   logic [DATA_W-1:0]  w_bop;
   logic [DATA_W-1:0]  w_r;
   logic               w_cin;
   logic               w_co;
   logic               w_so;
   logic               w_c_next;
   logic               w_z_next;
   logic               w_flag_en;

   assign w_bop = bus.ID_EX_alu_in_mux ? bus.ID_EX_instruction[IMM_MSB:IMM_LSB] : bus.ID_EX_B;
   assign w_cin = bus.ID_EX_alu_use_carry & r_c;

   alu_core u_alu (
      .i_a   (bus.ID_EX_A),
      .i_bop (w_bop),
      .i_cin (w_cin),
      .i_op  (alu_op_t'(bus.ID_EX_alu_op)),
      .o_r   (w_r),
      .o_co  (w_co),
      .o_so  (w_so)
   );

   assign w_c_next  = bus.ID_EX_select_c ? w_so : w_co;
   // With select_z the old Z is ANDed in so multi-byte compares chain.
   assign w_z_next  = (w_r == '0) & (~bus.ID_EX_select_z | r_z);
   assign w_flag_en = ~bus.stall & ~bus.flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result        <= '0;
         r_b             <= '0;
         r_instr         <= '0;
         r_mem_write     <= 1'b0;
         r_reg_write     <= 1'b0;
         r_reg_write_mux <= '0;
      end else if (!bus.stall) begin
         if (bus.flush) begin
            r_result        <= '0;
            r_b             <= '0;
            r_instr         <= '0;
            r_mem_write     <= 1'b0;
            r_reg_write     <= 1'b0;
            r_reg_write_mux <= '0;
         end else begin
            r_result        <= w_r;
            r_b             <= bus.ID_EX_B;
            r_instr         <= bus.ID_EX_instruction;
            r_mem_write     <= bus.ID_EX_mem_write;
            r_reg_write     <= bus.ID_EX_reg_write;
            r_reg_write_mux <= bus.ID_EX_reg_write_mux;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_c <= 1'b0;
         r_z <= 1'b0;
      end else if (w_flag_en) begin
         if (bus.ID_EX_write_c) r_c <= w_c_next;
         if (bus.ID_EX_write_z) r_z <= w_z_next;
      end
   end

   assign bus.EX_MEM_result        = r_result;
   assign bus.EX_MEM_B             = r_b;
   assign bus.EX_MEM_instruction   = r_instr;
   assign bus.EX_MEM_mem_write     = r_mem_write;
   assign bus.EX_MEM_reg_write     = r_reg_write;
   assign bus.EX_MEM_reg_write_mux = r_reg_write_mux;
   assign bus.carry_flag           = r_c;
   assign bus.zero_flag            = r_z;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
   import ex_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   ex_mem_stage_if bus();

   ex_mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0]  m_res, m_b;
   logic [18:0] m_instr;
   logic        m_mw, m_rw, m_c, m_z;
   logic [1:0]  m_rwm;
   logic        nx_c, nx_z;
   int          ma, mb, mcin, ms, mr, mco, mso;

   initial begin
      m_res = '0; m_b = '0; m_instr = '0; m_mw = 0; m_rw = 0; m_rwm = '0; m_c = 0; m_z = 0;
   end

   always_comb begin
      ma   = int'(bus.ID_EX_A);
      mb   = bus.ID_EX_alu_in_mux ? int'(bus.ID_EX_instruction[7:0]) : int'(bus.ID_EX_B);
      mcin = (bus.ID_EX_alu_use_carry && m_c) ? 1 : 0;
      ms = 0; mr = 0; mco = 0; mso = 0;
      case (bus.ID_EX_alu_op)
         3'd0: begin ms = ma + mb + mcin; mr = ms % 256; mco = (ms > 255) ? 1 : 0; end
         3'd1: begin ms = ma - mb - mcin; mco = (ms < 0) ? 1 : 0; mr = (ms + 256) % 256; end
         3'd2: mr = ma & mb;
         3'd3: mr = ma | mb;
         3'd4: mr = ma ^ mb;
         3'd5: begin mr = (ma * 2) % 256 + mcin; mso = ma / 128; end
         3'd6: begin mr = ma / 2 + mcin * 128; mso = ma % 2; end
         default: begin mr = ma / 2 + (ma % 2) * 128; mso = ma % 2; end
      endcase
      nx_c = m_c;
      if (bus.ID_EX_write_c) nx_c = bus.ID_EX_select_c ? (mso != 0) : (mco != 0);
      nx_z = m_z;
      if (bus.ID_EX_write_z) nx_z = bus.ID_EX_select_z ? ((mr == 0) && m_z) : (mr == 0);
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_res <= '0; m_b <= '0; m_instr <= '0; m_mw <= 0; m_rw <= 0; m_rwm <= '0;
         m_c <= 0; m_z <= 0;
      end else if (!bus.stall) begin
         if (bus.flush) begin
            m_res <= '0; m_b <= '0; m_instr <= '0; m_mw <= 0; m_rw <= 0; m_rwm <= '0;
         end else begin
            m_res   <= 8'(mr);
            m_b     <= bus.ID_EX_B;
            m_instr <= bus.ID_EX_instruction;
            m_mw    <= bus.ID_EX_mem_write;
            m_rw    <= bus.ID_EX_reg_write;
            m_rwm   <= bus.ID_EX_reg_write_mux;
            m_c     <= nx_c;
            m_z     <= nx_z;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      chk("cmp_result", 32'(bus.EX_MEM_result),        32'(m_res));
      chk("cmp_B",      32'(bus.EX_MEM_B),             32'(m_b));
      chk("cmp_instr",  32'(bus.EX_MEM_instruction),   32'(m_instr));
      chk("cmp_mw",     32'(bus.EX_MEM_mem_write),     32'(m_mw));
      chk("cmp_rw",     32'(bus.EX_MEM_reg_write),     32'(m_rw));
      chk("cmp_rwm",    32'(bus.EX_MEM_reg_write_mux), 32'(m_rwm));
      chk("cmp_C",      32'(bus.carry_flag),           32'(m_c));
      chk("cmp_Z",      32'(bus.zero_flag),            32'(m_z));
   end

   // ---------------- stimulus helpers ----------------
   task automatic drv(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [18:0] ins, input logic mux, input logic uc,
                      input logic sc, input logic sz, input logic wc, input logic wz,
                      input logic mw, input logic rw, input logic [1:0] rwm);
      bus.ID_EX_alu_op        = op;
      bus.ID_EX_A             = a;
      bus.ID_EX_B             = b;
      bus.ID_EX_instruction   = ins;
      bus.ID_EX_alu_in_mux    = mux;
      bus.ID_EX_alu_use_carry = uc;
      bus.ID_EX_select_c      = sc;
      bus.ID_EX_select_z      = sz;
      bus.ID_EX_write_c       = wc;
      bus.ID_EX_write_z       = wz;
      bus.ID_EX_mem_write     = mw;
      bus.ID_EX_reg_write     = rw;
      bus.ID_EX_reg_write_mux = rwm;
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_out(input string nm, input logic [7:0] res, input logic c, input logic z);
      chk({nm, "_result"}, 32'(bus.EX_MEM_result), 32'(res));
      chk({nm, "_C"},      32'(bus.carry_flag),    32'(c));
      chk({nm, "_Z"},      32'(bus.zero_flag),     32'(z));
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drv(ALU_ADD, 8'hF0, 8'h20, 19'h12345, 0, 0, 0, 0, 1, 1, 1, 1, 2'd2);
      #1 reset = 1'b0;
      #1;
      chk("rst0_result", 32'(bus.EX_MEM_result), 0);
      chk("rst0_mw",     32'(bus.EX_MEM_mem_write), 0);
      @(posedge clk); #2;
      reset = 1'b1;

      // first edge after release loads the ADD
      cyc();
      chk_out("add1", 8'h10, 1, 0);
      chk("add1_B",     32'(bus.EX_MEM_B), 32'h20);
      chk("add1_instr", 32'(bus.EX_MEM_instruction), 32'h12345);
      chk("add1_mw",    32'(bus.EX_MEM_mem_write), 1);
      chk("add1_rwm",   32'(bus.EX_MEM_reg_write_mux), 2);
      chk("mdl_add1",   32'(m_res), 32'h10);

      drv(ALU_ADD, 8'h00, 8'h00, 19'h00000, 0, 1, 0, 0, 0, 0, 0, 1, 2'd1);
      cyc(); chk_out("addc", 8'h01, 1, 0);

      drv(ALU_SUB, 8'h05, 8'h77, 19'h00005, 1, 0, 0, 0, 1, 1, 0, 1, 2'd0);
      cyc(); chk_out("subimm", 8'h00, 0, 1);
      chk("subimm_B", 32'(bus.EX_MEM_B), 32'h77);

      drv(ALU_SUB, 8'h03, 8'h04, 19'h00099, 0, 0, 0, 0, 1, 1, 0, 1, 2'd0);
      cyc(); chk_out("subbor", 8'hFF, 1, 0);
      chk("mdl_subbor", 32'(m_c), 1);

      drv(ALU_SHR, 8'h81, 8'h00, 19'h00000, 0, 1, 1, 0, 1, 0, 0, 1, 2'd0);
      cyc(); chk_out("shr", 8'hC0, 1, 0);

      drv(ALU_ROR, 8'h02, 8'h00, 19'h00000, 0, 1, 1, 0, 1, 0, 0, 1, 2'd0);
      cyc(); chk_out("ror", 8'h01, 0, 0);

      drv(ALU_AND, 8'h00, 8'hFF, 19'h00000, 0, 0, 0, 1, 0, 1, 0, 1, 2'd0);
      cyc(); chk_out("chainz0", 8'h00, 0, 0);

      drv(ALU_SUB, 8'h05, 8'h05, 19'h00000, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0);
      cyc(); chk_out("setz", 8'h00, 0, 1);

      drv(ALU_OR, 8'h00, 8'h00, 19'h00000, 0, 0, 0, 1, 0, 1, 0, 1, 2'd0);
      cyc(); chk_out("chainz1", 8'h00, 0, 1);

      drv(ALU_XOR, 8'h3C, 8'h0F, 19'h00000, 0, 0, 0, 1, 0, 1, 0, 1, 2'd0);
      cyc(); chk_out("chainznz", 8'h33, 0, 0);

      drv(ALU_ADD, 8'hFF, 8'h01, 19'h7ABCD, 0, 0, 0, 0, 1, 1, 0, 1, 2'd3);
      cyc(); chk_out("wrap", 8'h00, 1, 1);
      chk("mdl_wrap_Z", 32'(m_z), 1);

      // stall: two cycles with changing inputs, then stall+flush
      bus.stall = 1'b1;
      drv(ALU_ADD, 8'h10, 8'h10, 19'h11111, 0, 0, 0, 0, 1, 1, 1, 0, 2'd1);
      cyc(); chk_out("stall1", 8'h00, 1, 1);
      drv(ALU_XOR, 8'hAA, 8'h55, 19'h22222, 0, 0, 1, 0, 1, 1, 1, 0, 2'd2);
      cyc(); chk_out("stall2", 8'h00, 1, 1);
      chk("stall2_instr", 32'(bus.EX_MEM_instruction), 32'h7ABCD);
      bus.flush = 1'b1;
      cyc(); chk_out("stallfl", 8'h00, 1, 1);
      chk("stallfl_instr", 32'(bus.EX_MEM_instruction), 32'h7ABCD);
      chk("stallfl_rwm",   32'(bus.EX_MEM_reg_write_mux), 3);

      bus.stall = 1'b0;
      drv(ALU_ADD, 8'h01, 8'h01, 19'h33333, 0, 0, 0, 0, 1, 1, 1, 1, 2'd2);
      cyc(); chk_out("flush", 8'h00, 1, 1);
      chk("flush_instr", 32'(bus.EX_MEM_instruction), 0);
      chk("flush_rw",    32'(bus.EX_MEM_reg_write), 0);
      chk("flush_mw",    32'(bus.EX_MEM_mem_write), 0);
      bus.flush = 1'b0;

      drv(ALU_SHL, 8'h80, 8'h00, 19'h44444, 0, 1, 1, 0, 1, 1, 1, 1, 2'd1);
      cyc(); chk_out("shl", 8'h01, 1, 0);

      // async reset mid-cycle from non-zero state
      reset = 1'b0;
      #1;
      chk_out("rstmid", 8'h00, 0, 0);
      chk("rstmid_instr", 32'(bus.EX_MEM_instruction), 0);
      cyc();
      reset = 1'b1;

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         drv(3'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
             8'($urandom), 19'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             2'($urandom));
         bus.stall = ($urandom_range(0, 7) == 0);
         bus.flush = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
         cyc();
      end
      reset = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      cyc();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
